// File: rtl/stack_spill_if.sv
// Stack/spill bus: CPU push/pop side plus backing-memory request side.
// The master is whoever drives the CPU ops and answers memory requests;
// the stack itself sits on the slave modport.
interface stack_spill_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 8
);
  logic [WIDTH-1:0] in;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             ovf;
  logic             und;
  logic             mem_req;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    output in, push, pop, mem_rdata, mem_ack,
    input  out, busy, ovf, und, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in, push, pop, mem_rdata, mem_ack,
    output out, busy, ovf, und, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/stack_spill.sv
// Hardware stack with a small on-chip circular buffer that spills its
// bottom entries to a backing memory when it fills up and refills them
// when it runs low. The CPU only ever sees the top of stack.
module stack_spill #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int HI    = 12,
  parameter int LO    = 4
) (
  input  logic            clk,
  input  logic            reset,
  stack_spill_if.slave    bus
);
  localparam int N  = 1 << DEPTH;
  localparam int M  = 1 << AW;
  localparam int CW = DEPTH + 1;
  localparam int EW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [CW-1:0] CNT_HI   = CW'(HI);
  localparam logic [CW-1:0] CNT_LO   = CW'(LO);
  localparam logic [EW-1:0] EXT_FULL = EW'(M);

  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [N];
  logic [DEPTH-1:0] bot_q, bot_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [EW-1:0]    ext_q, ext_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             und_q, und_d;

  logic             busy;
  logic             push_acc, pop_acc;
  logic             spill_ack, fill_ack;
  logic [DEPTH-1:0] push_slot, fill_slot, top_d;
  logic [AW-1:0]    fill_addr;

  // Stall while the buffer is full, or empty with entries still parked in memory.
  assign busy      = (cnt_q == CNT_FULL) || ((cnt_q == '0) && (ext_q != '0));
  // Push wins over a simultaneous pop.
  assign push_acc  = !busy && bus.push;
  assign pop_acc   = !busy && !bus.push && bus.pop && (cnt_q != '0);
  // An ack only counts while a request is actually outstanding.
  assign spill_ack = bus.mem_ack && (state_q == SPILL);
  assign fill_ack  = bus.mem_ack && (state_q == FILL);
  assign push_slot = bot_q + cnt_q[DEPTH-1:0];
  assign fill_slot = bot_q - DEPTH'(1);
  assign fill_addr = AW'(ext_q - EW'(1));

  // Next-state datapath: CPU op and memory completion deltas combine in one edge.
  always_comb begin
    cnt_d = cnt_q;
    bot_d = bot_q;
    ext_d = ext_q;
    if (push_acc)  cnt_d = cnt_d + CW'(1);
    if (pop_acc)   cnt_d = cnt_d - CW'(1);
    if (spill_ack) begin
      cnt_d = cnt_d - CW'(1);
      bot_d = bot_q + DEPTH'(1);
      ext_d = ext_q + EW'(1);
    end
    if (fill_ack) begin
      cnt_d = cnt_d + CW'(1);
      bot_d = fill_slot;
      ext_d = ext_q - EW'(1);
    end
    und_d = und_q | (!busy && !bus.push && bus.pop && (cnt_q == '0) && (ext_q == '0));
    ovf_d = ovf_q | (bus.push && (cnt_q == CNT_FULL) && (ext_q == EXT_FULL));
    top_d = bot_d + cnt_d[DEPTH-1:0] - DEPTH'(1);
  end

  // Registered top of stack reflects this edge's writes, bypassing the array.
  always_comb begin
    out_d = '0;
    if (cnt_d != '0) begin
      if (push_acc)                             out_d = bus.in;
      else if (fill_ack && (top_d == fill_slot)) out_d = bus.mem_rdata;
      else                                      out_d = mem_q[top_d];
    end
  end

  // Transfer FSM: from IDLE start at most one transfer, spill has priority.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if ((cnt_q >= CNT_HI) && (ext_q < EXT_FULL))  state_d = SPILL;
        else if ((cnt_q <= CNT_LO) && (ext_q != '0)) state_d = FILL;
      end
      SPILL, FILL: if (bus.mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bot_q   <= '0;
      ext_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bot_q   <= bot_d;
      ext_q   <= ext_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      und_q   <= und_d;
    end
  end

  // Entry storage: pushes land above the top, fills land below the bottom.
  always_ff @(posedge clk) begin
    if (!reset && push_acc) mem_q[push_slot] <= bus.in;
    if (!reset && fill_ack) mem_q[fill_slot] <= bus.mem_rdata;
  end

  assign bus.out       = out_q;
  assign bus.busy      = busy;
  assign bus.ovf       = ovf_q;
  assign bus.und       = und_q;
  assign bus.mem_req   = (state_q != IDLE);
  assign bus.mem_we    = (state_q == SPILL);
  assign bus.mem_addr  = (state_q == SPILL) ? ext_q[AW-1:0] :
                         (state_q == FILL)  ? fill_addr     : '0;
  assign bus.mem_wdata = (state_q == SPILL) ? mem_q[bot_q]  : '0;
endmodule

// File: tb/tb_stack_spill.sv
// Bench for stack_spill: stimulus drives CPU ops and plays the backing
// memory, a queue-based stack model predicts every post-edge observation,
// and an independent monitor pops and compares those predictions.
module tb_stack_spill;
  localparam int WIDTH = 16, DEPTH = 4, AW = 8, HI = 12, LO = 4;
  localparam int N = 1 << DEPTH;
  localparam int M = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_spill_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
  stack_spill #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .HI(HI), .LO(LO))
    dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int         cyc;
    logic [15:0] out;
    logic       busy, ovf, und, req, we;
    logic [7:0] addr;
    logic [15:0] wdata;
    int         cnt, ext;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0, checks = 0, ecnt = 0;

  // Reference model: whole stack as queue of on-chip entries plus memory image.
  logic [15:0] oc[$];
  logic [15:0] bmem [M];
  int  ext = 0, xfer = 0, age = 0, lat = 0;   // xfer: 0 none, 1 spill, 2 fill
  bit  m_ovf = 0, m_und = 0, hold_ack = 0, junk = 0, rand_lat = 0;

  function automatic bit mbusy();
    return (oc.size() == N) || (oc.size() == 0 && ext != 0);
  endfunction

  function automatic bit quiet();
    return xfer == 0 && !(oc.size() >= HI && ext < M) && !(oc.size() <= LO && ext > 0);
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.cyc   = ecnt + 1;
    e.cnt   = oc.size();
    e.ext   = ext;
    e.out   = (e.cnt > 0) ? oc[e.cnt-1] : 16'h0;
    e.busy  = (e.cnt == N) || (e.cnt == 0 && ext != 0);
    e.ovf   = m_ovf;
    e.und   = m_und;
    e.req   = (xfer != 0);
    e.we    = (xfer == 1);
    e.addr  = (xfer == 1) ? 8'(ext) : (xfer == 2) ? 8'(ext - 1) : 8'h0;
    e.wdata = (xfer == 1) ? oc[0] : 16'h0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock of stimulus; model predicts the state after the coming edge.
  task automatic step(input bit p, input bit q, input logic [15:0] d);
    bit ack, bz;
    int cnt0, ext0;
    logic [15:0] v;
    @(negedge clk);
    reset = 1'b0;
    cnt0 = oc.size();
    ext0 = ext;
    bz   = mbusy();
    if (xfer != 0) ack = !hold_ack && (age >= lat);
    else           ack = junk && ($urandom_range(0, 1) == 1);
    bus.push = p; bus.pop = q; bus.in = d; bus.mem_ack = ack;
    bus.mem_rdata = (xfer == 2) ? bmem[ext0-1] : 16'($urandom);
    if (xfer == 1 && ack) begin v = oc.pop_front(); bmem[ext] = v; ext++; end
    if (xfer == 2 && ack) begin oc.push_front(bmem[ext-1]); ext--; end
    if (!bz) begin
      if (p) oc.push_back(d);
      else if (q) begin
        if (cnt0 > 0) void'(oc.pop_back());
        else m_und = 1;
      end
    end else if (p && cnt0 == N && ext0 == M) m_ovf = 1;
    if (xfer != 0) begin
      if (ack) xfer = 0;
      age++;
    end else begin
      age = 0;
      if (cnt0 >= HI && ext0 < M)     xfer = 1;
      else if (cnt0 <= LO && ext0 > 0) xfer = 2;
      if (xfer != 0 && rand_lat) lat = $urandom_range(0, 3);
    end
    sbq.push_back(snap());
  endtask

  task automatic model_reset();
    oc.delete(); ext = 0; xfer = 0; age = 0; m_ovf = 0; m_und = 0;
  endtask

  // Reset held across one edge; the following step releases it.
  task automatic rst();
    @(negedge clk);
    reset = 1'b1; bus.push = 0; bus.pop = 0; bus.mem_ack = 0;
    model_reset();
    sbq.push_back(snap());
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  task automatic push_wait(input logic [15:0] d);
    int k;
    for (k = 0; k < 200 && mbusy(); k++) step(0, 0, 16'h0);
    chk("push_wait_bound", 32'(k < 200), 1);
    step(1, 0, d);
  endtask

  task automatic pop_wait();
    int k;
    for (k = 0; k < 200 && mbusy(); k++) step(0, 0, 16'h0);
    chk("pop_wait_bound", 32'(k < 200), 1);
    step(0, 1, 16'h0);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 3000 && !quiet(); k++) step(0, 0, 16'h0);
    chk("drain_bound", 32'(k < 3000), 1);
  endtask

  // Monitor: after each edge compare everything predicted for that edge.
  initial begin
    exp_t e;
    bit bad;
    forever begin
      @(posedge clk);
      ecnt++;
      #1;
      while (sbq.size() > 0 && sbq[0].cyc <= ecnt) begin
        e = sbq.pop_front();
        checks++;
        bad = (bus.out !== e.out) || (bus.busy !== e.busy) || (bus.ovf !== e.ovf) ||
              (bus.und !== e.und) || (bus.mem_req !== e.req) ||
              (e.req && (bus.mem_we !== e.we || bus.mem_addr !== e.addr)) ||
              (e.we && bus.mem_wdata !== e.wdata) ||
              (int'(dut.cnt_q) != e.cnt) || (int'(dut.ext_q) != e.ext);
        if (bad) begin
          errors++;
          $display("FAIL edge%0d: got out=%h busy=%b ovf=%b und=%b req=%b we=%b addr=%0d wd=%h cnt=%0d ext=%0d expected out=%h busy=%b ovf=%b und=%b req=%b we=%b addr=%0d wd=%h cnt=%0d ext=%0d",
                   e.cyc, bus.out, bus.busy, bus.ovf, bus.und, bus.mem_req, bus.mem_we,
                   bus.mem_addr, bus.mem_wdata, dut.cnt_q, dut.ext_q,
                   e.out, e.busy, e.ovf, e.und, e.req, e.we, e.addr, e.wdata, e.cnt, e.ext);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.push = 0; bus.pop = 0; bus.in = '0; bus.mem_ack = 0; bus.mem_rdata = '0;
    #1;
    chk("async_reset_out", 32'(bus.out), 0);
    chk("async_reset_req", 32'(bus.mem_req), 0);
    rst();

    // Pop on empty flags underflow; later pushes still work and und sticks.
    step(0, 1, 16'h0);
    settle();
    chk("und_set", 32'(bus.und), 1);
    chk("und_out", 32'(bus.out), 0);
    for (int i = 1; i <= 5; i++) push_wait(16'(i + 100));
    settle();
    chk("und_sticky", 32'(bus.und), 1);

    // First spill after 12 pushes: bottom entry 1 goes to address 0.
    rst();
    lat = 2;
    for (int i = 1; i <= 12; i++) push_wait(16'(i));
    step(0, 0, 16'h0);
    settle();
    chk("spill_req", 32'(bus.mem_req), 1);
    chk("spill_we", 32'(bus.mem_we), 1);
    chk("spill_addr", 32'(bus.mem_addr), 0);
    chk("spill_wdata", 32'(bus.mem_wdata), 1);
    drain();
    settle();
    chk("spill_cnt", 32'(dut.cnt_q), 11);
    chk("spill_ext", 32'(dut.ext_q), 1);

    // Deep push of 40 then pop of 40 with one-cycle ack latency.
    rst();
    lat = 1;
    for (int i = 1; i <= 40; i++) push_wait(16'(i));
    drain();
    settle();
    chk("deep_ext", 32'(dut.ext_q), 29);
    chk("deep_cnt", 32'(dut.cnt_q), 11);
    for (int i = 40; i >= 1; i--) begin
      for (int k = 0; k < 200 && mbusy(); k++) step(0, 0, 16'h0);
      settle();
      chk("deep_pop_top", 32'(bus.out), 32'(i));
      pop_wait();
    end
    drain();
    settle();
    chk("deep_empty_out", 32'(bus.out), 0);
    chk("deep_und", 32'(bus.und), 0);

    // Ack withheld: buffer fills, busy stalls, extra push is dropped quietly.
    rst();
    hold_ack = 1; lat = 0;
    for (int i = 1; i <= 16; i++) push_wait(16'(i + 16'h200));
    step(1, 0, 16'h5555);
    settle();
    chk("full_busy", 32'(bus.busy), 1);
    chk("full_ovf", 32'(bus.ovf), 0);
    chk("full_cnt", 32'(dut.cnt_q), 16);
    hold_ack = 0;
    step(0, 0, 16'h0);
    settle();
    chk("full_release", 32'(bus.busy), 0);
    drain();

    // Push and pop together: push wins.
    rst();
    for (int i = 1; i <= 3; i++) push_wait(16'(i));
    step(1, 1, 16'hABCD);
    settle();
    chk("pushpop_cnt", 32'(dut.cnt_q), 4);
    chk("pushpop_out", 32'(bus.out), 32'hABCD);

    // Reset in the middle of a pending fill.
    rst();
    lat = 0;
    for (int i = 1; i <= 20; i++) push_wait(16'(i + 16'h300));
    drain();
    hold_ack = 1;
    for (int k = 0; k < 40 && xfer != 2; k++) begin
      if (!mbusy() && oc.size() > LO) step(0, 1, 16'h0);
      else step(0, 0, 16'h0);
    end
    @(negedge clk);
    chk("fill_req_before", 32'(bus.mem_req), 1);
    #2;
    reset = 1'b1; bus.push = 0; bus.pop = 0;
    #1;
    chk("midrst_req", 32'(bus.mem_req), 0);
    chk("midrst_out", 32'(bus.out), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    model_reset();
    sbq.push_back(snap());
    hold_ack = 0;

    // Overflow: memory and buffer both full, then a push sets ovf.
    step(0, 0, 16'h0);
    for (int i = 0; i < 800; i++) step(1, 0, 16'($urandom));
    settle();
    chk("ovf_set", 32'(bus.ovf), 1);
    chk("ovf_ext", 32'(dut.ext_q), 32'(M));
    step(0, 1, 16'h0);

    // Randomized traffic: balanced, push-heavy, pop-heavy, random latency, stray acks.
    rst();
    rand_lat = 1; junk = 1;
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bit p, q;
      bias = (i < 1000) ? 50 : (i < 2000) ? 75 : 25;
      p = ($urandom_range(0, 99) < bias);
      q = ($urandom_range(0, 99) < (100 - bias));
      step(p, q, 16'($urandom));
    end
    junk = 0;
    drain();
    settle();
    settle();
    chk("scoreboard_empty", 32'(sbq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
